// File: rtl/imm_extend_pipe_pkg.sv
// rtl/imm_extend_pipe_pkg.sv - immediate format encodings and XLEN legality constants
package imm_pkg;

    typedef enum logic [2:0] {
        IMM_I   = 3'b000,
        IMM_S   = 3'b001,
        IMM_B   = 3'b010,
        IMM_J   = 3'b011,
        IMM_U   = 3'b100,
        IMM_Z   = 3'b101,
        IMM_SH  = 3'b110,
        IMM_RSV = 3'b111
    } immsrc_t;

    localparam int XLEN_32 = 32;
    localparam int XLEN_64 = 64;

    function automatic bit xlen_legal(input int xlen);
        return (xlen == XLEN_32) || (xlen == XLEN_64);
    endfunction

endpackage

// File: rtl/imm_extend_pipe_if.sv
// rtl/imm_extend_pipe_if.sv - request/response handshake bundle for the immediate pipe
interface imm_extend_pipe_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [31:7]      instr;
    logic [2:0]       immsrc;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  immext;
    logic [TAG_W-1:0] out_tag;
    logic             illegal;

    modport master (
        output in_valid, instr, immsrc, in_tag, out_ready,
        input  in_ready, out_valid, immext, out_tag, illegal
    );

    modport slave (
        input  in_valid, instr, immsrc, in_tag, out_ready,
        output in_ready, out_valid, immext, out_tag, illegal
    );
endinterface

// File: rtl/imm_extend_pipe_decode_core.sv
// rtl/imm_extend_pipe_decode_core.sv - combinational immediate extraction and extension
module imm_decode_core
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:7]     instr,
    input  immsrc_t         immsrc,
    output logic [XLEN-1:0] imm,
    output logic            illegal
);
    logic [31:0] imm32;

    // Every format is first formed as a 32-bit value; zero-extended formats have bit 31 clear,
    // so one signed widening serves both the sign- and zero-extended cases at XLEN=64.
    always_comb begin
        imm32   = '0;
        illegal = 1'b0;
        case (immsrc)
            IMM_I:  imm32 = {{20{instr[31]}}, instr[31:20]};
            IMM_S:  imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:  imm32 = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_J:  imm32 = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
            IMM_U:  imm32 = {instr[31:12], 12'b0};
            IMM_Z:  imm32 = {27'b0, instr[19:15]};
            IMM_SH: imm32 = (XLEN == XLEN_64) ? {26'b0, instr[25:20]} : {27'b0, instr[24:20]};
            default: begin
                imm32   = '0;
                illegal = 1'b1;
            end
        endcase
        imm = XLEN'($signed(imm32));
    end
endmodule

// File: rtl/imm_extend_pipe.sv
// rtl/imm_extend_pipe.sv - registered immediate generator with main/skid handshake buffer
module imm_extend_pipe
    import imm_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    imm_extend_pipe_if.slave bus
);
    logic [XLEN-1:0]  dec_imm;
    logic             dec_ill;

    logic             main_valid;
    logic [XLEN-1:0]  main_imm;
    logic [TAG_W-1:0] main_tag;
    logic             main_ill;

    logic             skid_valid;
    logic [XLEN-1:0]  skid_imm;
    logic [TAG_W-1:0] skid_tag;
    logic             skid_ill;

    logic             accept;
    logic             xfer;

    imm_decode_core #(.XLEN(XLEN)) u_core (
        .instr   (bus.instr),
        .immsrc  (immsrc_t'(bus.immsrc)),
        .imm     (dec_imm),
        .illegal (dec_ill)
    );

    // in_ready comes straight from the skid flop, so it never sees out_ready combinationally.
    assign bus.in_ready = !skid_valid;
    assign accept       = bus.in_valid && !skid_valid;
    assign xfer         = main_valid && bus.out_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            main_valid <= 1'b0;
            main_imm   <= '0;
            main_tag   <= '0;
            main_ill   <= 1'b0;
            skid_valid <= 1'b0;
            skid_imm   <= '0;
            skid_tag   <= '0;
            skid_ill   <= 1'b0;
        end else if (flush) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (!main_valid || xfer) begin
            if (skid_valid) begin
                main_valid <= 1'b1;
                main_imm   <= skid_imm;
                main_tag   <= skid_tag;
                main_ill   <= skid_ill;
                skid_valid <= 1'b0;
            end else if (accept) begin
                main_valid <= 1'b1;
                main_imm   <= dec_imm;
                main_tag   <= bus.in_tag;
                main_ill   <= dec_ill;
            end else begin
                main_valid <= 1'b0;
            end
        end else if (accept) begin
            skid_valid <= 1'b1;
            skid_imm   <= dec_imm;
            skid_tag   <= bus.in_tag;
            skid_ill   <= dec_ill;
        end
    end

    // Stale main contents are masked so the outputs read zero whenever nothing is presented.
    assign bus.out_valid = main_valid;
    assign bus.immext    = main_valid ? main_imm : '0;
    assign bus.out_tag   = main_valid ? main_tag : '0;
    assign bus.illegal   = main_valid && main_ill;
endmodule

// File: tb/tb_imm_extend_pipe.sv
// tb/tb_imm_extend_pipe.sv - directed self-checking bench for imm_extend_pipe at XLEN 32 and 64
module tb_imm_extend_pipe;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic flush = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    imm_extend_pipe_if #(.XLEN(32), .TAG_W(5)) b32 ();
    imm_extend_pipe_if #(.XLEN(64), .TAG_W(5)) b64 ();

    imm_extend_pipe #(.XLEN(32), .TAG_W(5)) dut32 (
        .clk(clk), .reset_n(reset_n), .flush(flush), .bus(b32.slave));
    imm_extend_pipe #(.XLEN(64), .TAG_W(5)) dut64 (
        .clk(clk), .reset_n(reset_n), .flush(flush), .bus(b64.slave));

    function automatic logic [31:0] i_word(input logic [4:0] tag);
        return {7'b0, tag, 20'h00013};
    endfunction

    task automatic drive32(input logic [31:0] w, input logic [2:0] src, input logic [4:0] tag);
        b32.instr    = w[31:7];
        b32.immsrc   = src;
        b32.in_tag   = tag;
        b32.in_valid = 1'b1;
    endtask

    task automatic one32(input logic [31:0] w, input logic [2:0] src, input logic [4:0] tag,
                         input logic [31:0] exp, input logic exp_ill, input string name);
        @(negedge clk);
        drive32(w, src, tag);
        b32.out_ready = 1'b1;
        @(posedge clk);
        #1;
        b32.in_valid = 1'b0;
        checks++;
        if (b32.out_valid !== 1'b1 || b32.immext !== exp || b32.illegal !== exp_ill || b32.out_tag !== tag) begin
            failures++;
            $display("FAIL %s: valid=%0b imm=%0h ill=%0b tag=%0d expected valid=1 imm=%0h ill=%0b tag=%0d",
                     name, b32.out_valid, b32.immext, b32.illegal, b32.out_tag, exp, exp_ill, tag);
        end
        @(posedge clk);
        #1;
        checks++;
        if (b32.out_valid !== 1'b0 || b32.immext !== 32'h0) begin
            failures++;
            $display("FAIL %s_drain: valid=%0b imm=%0h expected valid=0 imm=0", name, b32.out_valid, b32.immext);
        end
    endtask

    task automatic one64(input logic [31:0] w, input logic [2:0] src, input logic [4:0] tag,
                         input logic [63:0] exp, input logic exp_ill, input string name);
        @(negedge clk);
        b64.instr     = w[31:7];
        b64.immsrc    = src;
        b64.in_tag    = tag;
        b64.in_valid  = 1'b1;
        b64.out_ready = 1'b1;
        @(posedge clk);
        #1;
        b64.in_valid = 1'b0;
        checks++;
        if (b64.out_valid !== 1'b1 || b64.immext !== exp || b64.illegal !== exp_ill || b64.out_tag !== tag) begin
            failures++;
            $display("FAIL %s: valid=%0b imm=%0h ill=%0b tag=%0d expected valid=1 imm=%0h ill=%0b tag=%0d",
                     name, b64.out_valid, b64.immext, b64.illegal, b64.out_tag, exp, exp_ill, tag);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (b32.out_valid !== 1'b0 || b32.immext !== 32'h0 || b32.out_tag !== 5'd0 ||
            b32.illegal !== 1'b0 || b32.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset32: valid=%0b imm=%0h tag=%0d ill=%0b rdy=%0b expected 0 0 0 0 1",
                     b32.out_valid, b32.immext, b32.out_tag, b32.illegal, b32.in_ready);
        end
        checks++;
        if (b64.out_valid !== 1'b0 || b64.immext !== 64'h0 || b64.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset64: valid=%0b imm=%0h rdy=%0b expected 0 0 1",
                     b64.out_valid, b64.immext, b64.in_ready);
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_formats32();
        one32(32'hFFF00093, 3'b000, 5'd1, 32'hFFFFFFFF, 1'b0, "i_fmt");
        one32(32'hFE112E23, 3'b001, 5'd2, 32'hFFFFFFFC, 1'b0, "s_fmt");
        one32(32'hFE000EE3, 3'b010, 5'd3, 32'hFFFFFFFC, 1'b0, "b_fmt");
        one32(32'h0010006F, 3'b011, 5'd4, 32'h00000800, 1'b0, "j_fmt");
        one32(32'h03F00013, 3'b110, 5'd5, 32'h0000001F, 1'b0, "sh_fmt32");
        one32(32'h000F8073, 3'b111, 5'd6, 32'h00000000, 1'b1, "rsv32");
    endtask

    task automatic test_formats64();
        one64(32'h800000B7, 3'b100, 5'd7, 64'hFFFFFFFF80000000, 1'b0, "u_fmt64");
        one64(32'h03F00013, 3'b110, 5'd8, 64'd63, 1'b0, "sh_fmt64");
        one64(32'h000F8073, 3'b101, 5'd9, 64'h1F, 1'b0, "z_fmt64");
        one64(32'hFFFFFFFF, 3'b111, 5'd10, 64'h0, 1'b1, "rsv64");
    endtask

    task automatic test_backpressure();
        logic [4:0] got_tag[$];
        logic [31:0] got_imm[$];
        bit drop;
        @(negedge clk);
        b32.out_ready = 1'b0;
        drive32(i_word(5'd1), 3'b000, 5'd1);
        @(negedge clk);
        drive32(i_word(5'd2), 3'b000, 5'd2);
        @(posedge clk);
        #1;
        checks++;
        if (b32.in_ready !== 1'b0) begin
            failures++;
            $display("FAIL bp_ready_low: in_ready=%0b expected 0", b32.in_ready);
        end
        @(negedge clk);
        drive32(i_word(5'd3), 3'b000, 5'd3);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (b32.out_valid !== 1'b1 || b32.out_tag !== 5'd1 || b32.immext !== 32'd1 || b32.in_ready !== 1'b0) begin
                failures++;
                $display("FAIL bp_stable: valid=%0b tag=%0d imm=%0h rdy=%0b expected 1 1 1 0",
                         b32.out_valid, b32.out_tag, b32.immext, b32.in_ready);
            end
        end
        b32.out_ready = 1'b1;
        drop = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (b32.out_valid) begin
                got_tag.push_back(b32.out_tag);
                got_imm.push_back(b32.immext);
            end
            if (drop) b32.in_valid = 1'b0;
            else if (b32.in_valid && b32.in_ready) drop = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (got_tag.size() != 3 || got_tag[0] !== 5'd1 || got_tag[1] !== 5'd2 || got_tag[2] !== 5'd3 ||
            got_imm[0] !== 32'd1 || got_imm[1] !== 32'd2 || got_imm[2] !== 32'd3) begin
            failures++;
            $display("FAIL bp_order: got %0d outputs %p expected tags 1 2 3", got_tag.size(), got_tag);
        end
    endtask

    task automatic test_flush();
        bit seen;
        @(negedge clk);
        b32.out_ready = 1'b0;
        drive32(i_word(5'd4), 3'b000, 5'd4);
        @(negedge clk);
        drive32(i_word(5'd5), 3'b000, 5'd5);
        @(negedge clk);
        drive32(i_word(5'd6), 3'b000, 5'd6);
        flush = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (b32.out_valid !== 1'b0 || b32.in_ready !== 1'b1 || b32.immext !== 32'h0) begin
            failures++;
            $display("FAIL flush_full: valid=%0b rdy=%0b imm=%0h expected 0 1 0",
                     b32.out_valid, b32.in_ready, b32.immext);
        end
        @(negedge clk);
        flush = 1'b0;
        b32.in_valid = 1'b0;
        b32.out_ready = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (b32.out_valid) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            failures++;
            $display("FAIL flush_no_leak: out_valid seen=%0b expected 0", seen);
        end
        drive32(i_word(5'd7), 3'b000, 5'd7);
        flush = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (b32.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL flush_discard_accept: out_valid=%0b expected 0", b32.out_valid);
        end
        @(negedge clk);
        flush = 1'b0;
        b32.in_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        b32.out_ready = 1'b0;
        drive32(i_word(5'd8), 3'b000, 5'd8);
        @(negedge clk);
        drive32(i_word(5'd9), 3'b000, 5'd9);
        @(negedge clk);
        b32.in_valid = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (b32.out_valid !== 1'b0 || b32.immext !== 32'h0 || b32.out_tag !== 5'd0 ||
            b32.illegal !== 1'b0 || b32.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid: valid=%0b imm=%0h tag=%0d ill=%0b rdy=%0b expected 0 0 0 0 1",
                     b32.out_valid, b32.immext, b32.out_tag, b32.illegal, b32.in_ready);
        end
        @(negedge clk);
        reset_n = 1'b1;
        one32(32'hFFF00093, 3'b000, 5'd10, 32'hFFFFFFFF, 1'b0, "after_reset");
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        b32.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) begin
                checks++;
                if (b32.out_valid !== 1'b1 || b32.out_tag !== 5'(10 + i) || b32.immext !== 32'(10 + i)) begin
                    failures++;
                    $display("FAIL b2b_%0d: valid=%0b tag=%0d imm=%0h expected 1 %0d %0h",
                             i, b32.out_valid, b32.out_tag, b32.immext, 10 + i, 10 + i);
                end
            end
            if (i < 5) drive32(i_word(5'(11 + i)), 3'b000, 5'(11 + i));
            else b32.in_valid = 1'b0;
            @(negedge clk);
        end
    endtask

    initial begin
        b32.in_valid = 1'b0; b32.instr = '0; b32.immsrc = '0; b32.in_tag = '0; b32.out_ready = 1'b0;
        b64.in_valid = 1'b0; b64.instr = '0; b64.immsrc = '0; b64.in_tag = '0; b64.out_ready = 1'b0;
        test_reset();
        test_formats32();
        test_formats64();
        test_backpressure();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
